// File: rtl/cpu_core_if.sv
// Instruction fetch and data bus between cpu_core (master) and the SoC memories/devices (slave).
// Neither bus has back-pressure. Fetch data is valid one cycle after the address, loads likewise, and a store is accepted on the one cycle dbus_wvalid_o is high.
interface cpu_core_if #(
    parameter int IBUS_ADDR_WIDTH = 32,
    parameter int IBUS_DATA_WIDTH = 32,
    parameter int DBUS_ADDR_WIDTH = 32,
    parameter int DBUS_DATA_WIDTH = 32,
    parameter int DBUS_STRB_WIDTH = 4
);
    logic [IBUS_ADDR_WIDTH-1:0] ibus_araddr_o;
    logic [IBUS_DATA_WIDTH-1:0] ibus_rdata_i;
    logic [DBUS_ADDR_WIDTH-1:0] dbus_addr_o;
    logic                       dbus_wvalid_o;
    logic [DBUS_DATA_WIDTH-1:0] dbus_wdata_o;
    logic [DBUS_STRB_WIDTH-1:0] dbus_wstrb_o;
    logic [DBUS_DATA_WIDTH-1:0] dbus_rdata_i;
    logic [2:0]                 dbg_state;

    modport master (
        output ibus_araddr_o, dbus_addr_o, dbus_wvalid_o, dbus_wdata_o, dbus_wstrb_o, dbg_state,
        input  ibus_rdata_i, dbus_rdata_i
    );
    modport slave (
        input  ibus_araddr_o, dbus_addr_o, dbus_wvalid_o, dbus_wdata_o, dbus_wstrb_o, dbg_state,
        output ibus_rdata_i, dbus_rdata_i
    );
endinterface

// File: rtl/cpu_core.sv
// RV32I multi-cycle core: FETCH -> DECODE -> EXEC -> (MEM -> WB) -> FETCH.
// ALU ops take 3 cycles, stores 4, loads 5; no traps, unknown opcodes behave as NOPs.
module cpu_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          IBUS_ADDR_WIDTH = 32,
    parameter int          IBUS_DATA_WIDTH = 32,
    parameter int          DBUS_ADDR_WIDTH = 32,
    parameter int          DBUS_DATA_WIDTH = 32,
    parameter int          DBUS_STRB_WIDTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    cpu_core_if.master bus
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    state_t                     state;
    logic [IBUS_ADDR_WIDTH-1:0] pc;
    logic [IBUS_DATA_WIDTH-1:0] ir;
    logic [31:0]                rs1_v, rs2_v;
    logic [31:0]                regs [32];
    logic [DBUS_ADDR_WIDTH-1:0] addr_q;
    logic [DBUS_DATA_WIDTH-1:0] wdata_q;
    logic [DBUS_STRB_WIDTH-1:0] wstrb_q;
    logic                       wvalid_q;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1_idx, rs2_idx;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_y, rd_data, next_pc, eff_addr, load_val, st_wdata;
    logic [3:0]  st_wstrb;
    logic [4:0]  shamt;
    logic        taken, rd_we_exec, rf_we;
    logic [31:0] rf_wd;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign opcode  = ir[6:0];
    assign f3      = ir[14:12];
    assign rd      = ir[11:7];
    assign rs1_idx = bus.ibus_rdata_i[19:15];
    assign rs2_idx = bus.ibus_rdata_i[24:20];
    assign imm_i   = {{20{ir[31]}}, ir[31:20]};
    assign imm_s   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u   = {ir[31:12], 12'b0};
    assign imm_j   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign alu_b   = (opcode == OP_OP) ? rs2_v : imm_i;
    assign shamt   = alu_b[4:0];

    always_comb begin
        alu_y = 32'b0;
        case (f3)
            3'b000: alu_y = (opcode == OP_OP && ir[30]) ? rs1_v - alu_b : rs1_v + alu_b;
            3'b001: alu_y = rs1_v << shamt;
            3'b010: alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
            3'b011: alu_y = {31'b0, rs1_v < alu_b};
            3'b100: alu_y = rs1_v ^ alu_b;
            3'b101: alu_y = ir[30] ? 32'($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
            3'b110: alu_y = rs1_v | alu_b;
            default: alu_y = rs1_v & alu_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000: taken = rs1_v == rs2_v;
            3'b001: taken = rs1_v != rs2_v;
            3'b100: taken = $signed(rs1_v) < $signed(rs2_v);
            3'b101: taken = $signed(rs1_v) >= $signed(rs2_v);
            3'b110: taken = rs1_v < rs2_v;
            3'b111: taken = rs1_v >= rs2_v;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc    = pc + 32'd4;
        rd_data    = alu_y;
        rd_we_exec = 1'b0;
        case (opcode)
            OP_LUI:    begin rd_data = imm_u;        rd_we_exec = 1'b1; end
            OP_AUIPC:  begin rd_data = pc + imm_u;   rd_we_exec = 1'b1; end
            OP_JAL:    begin rd_data = pc + 32'd4;   rd_we_exec = 1'b1; next_pc = pc + imm_j; end
            OP_JALR:   begin rd_data = pc + 32'd4;   rd_we_exec = 1'b1;
                             next_pc = (rs1_v + imm_i) & ~32'd1; end
            OP_BRANCH: if (taken) next_pc = pc + imm_b;
            OP_IMM, OP_OP: rd_we_exec = 1'b1;
            default: ;
        endcase
    end

    // Store data is replicated across lanes; the strobes pick the live bytes.
    assign eff_addr = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
    always_comb begin
        st_wdata = rs2_v;
        st_wstrb = 4'b1111;
        case (f3[1:0])
            2'b00: begin st_wdata = {4{rs2_v[7:0]}};  st_wstrb = 4'b0001 << eff_addr[1:0]; end
            2'b01: begin st_wdata = {2{rs2_v[15:0]}}; st_wstrb = eff_addr[1] ? 4'b1100 : 4'b0011; end
            default: ;
        endcase
    end

    assign ld_byte = bus.dbus_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = addr_q[1] ? bus.dbus_rdata_i[31:16] : bus.dbus_rdata_i[15:0];
    always_comb begin
        case (f3)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'b0, ld_byte};
            3'b101:  load_val = {16'b0, ld_half};
            default: load_val = bus.dbus_rdata_i;
        endcase
    end

    assign rf_we = (state == S_EXEC && rd_we_exec) || state == S_WB;
    assign rf_wd = (state == S_WB) ? load_val : rd_data;

    always_ff @(posedge clk_i) begin
        if (rf_we && rd != 5'd0) regs[rd] <= rf_wd;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            rs1_v    <= '0;
            rs2_v    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            wvalid_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir    <= bus.ibus_rdata_i;
                    rs1_v <= (rs1_idx == 5'd0) ? 32'b0 : regs[rs1_idx];
                    rs2_v <= (rs2_idx == 5'd0) ? 32'b0 : regs[rs2_idx];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (opcode == OP_LOAD || opcode == OP_STORE) begin
                        addr_q <= eff_addr;
                        state  <= S_MEM;
                        if (opcode == OP_STORE) begin
                            wdata_q  <= st_wdata;
                            wstrb_q  <= st_wstrb;
                            wvalid_q <= 1'b1;
                        end
                    end else begin
                        pc    <= next_pc;
                        state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    wvalid_q <= 1'b0;
                    if (opcode == OP_STORE) begin
                        pc    <= pc + 32'd4;
                        state <= S_FETCH;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    pc    <= pc + 32'd4;
                    state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    assign bus.ibus_araddr_o = pc;
    assign bus.dbus_addr_o   = addr_q;
    assign bus.dbus_wdata_o  = wdata_q;
    assign bus.dbus_wstrb_o  = wstrb_q;
    assign bus.dbus_wvalid_o = wvalid_q;
    assign bus.dbg_state     = state;
endmodule

// File: tb/tb_cpu_core.sv
// Directed program for cpu_core; stores and fetch-address changes are compared against
// expected queues filled while the program is written.
module tb_cpu_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tracking = 1'b0;
    logic [31:0] imem [64];
    logic [31:0] load_word;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] last_pc = 32'h0;

    logic [67:0] exp_q [$];   // {addr, wdata, wstrb}
    logic [63:0] trace_q [$]; // {next fetch address, cycles spent on previous instruction}

    cpu_core_if bus ();

    cpu_core dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.ibus_rdata_i <= imem[bus.ibus_araddr_o[7:2]];
    assign bus.dbus_rdata_i = load_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [31:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd,
                                          input logic [31:0] op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3,
                                          input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word,
                       input logic [31:0] next_pc, input logic [31:0] gap);
        imem[addr[7:2]] = word;
        trace_q.push_back({next_pc, gap});
    endtask

    task automatic exp_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_q.push_back({addr, wdata, wstrb});
    endtask

    // Monitor: compares every fetch-address change and every store pulse.
    always @(negedge clk) begin
        if (tracking && !rst) begin
            logic [63:0] t;
            logic [67:0] s;
            cyc++;
            if (bus.ibus_araddr_o !== last_pc) begin
                if (trace_q.size() == 0) begin
                    check("unexpected_fetch", bus.ibus_araddr_o, last_pc);
                end else begin
                    t = trace_q.pop_front();
                    check("fetch_addr", bus.ibus_araddr_o, t[63:32]);
                    check("instr_cycles", cyc, t[31:0]);
                end
                last_pc = bus.ibus_araddr_o;
                cyc = 0;
            end
            if (bus.dbus_wvalid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_store_addr", bus.dbus_addr_o, 32'hDEAD_BEEF);
                end else begin
                    s = exp_q.pop_front();
                    check("st_addr", bus.dbus_addr_o, s[67:36]);
                    check("st_wdata", bus.dbus_wdata_o, s[35:4]);
                    check("st_wstrb", {28'b0, bus.dbus_wstrb_o}, {28'b0, s[3:0]});
                end
            end
        end
    end

    initial begin
        load_word = 32'h80FF_7F01;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;

        put(32'h00, enc_i(5, 0, 0, 1, 7'b0010011),        32'h04, 3);
        put(32'h04, enc_i(-3, 1, 0, 2, 7'b0010011),       32'h08, 3);
        put(32'h08, enc_r(0, 2, 1, 0, 3),                 32'h0C, 3);
        put(32'h0C, enc_s(32'h100, 3, 0, 2),              32'h10, 4);
        exp_store(32'h100, 32'h7, 4'b1111);
        put(32'h10, enc_j(8, 1),                          32'h18, 3);
        imem[5] = enc_i(1, 0, 0, 3, 7'b0010011);
        put(32'h18, enc_s(32'h104, 1, 0, 2),              32'h1C, 4);
        exp_store(32'h104, 32'h14, 4'b1111);
        put(32'h1C, enc_i(32'hA5, 0, 0, 1, 7'b0010011),   32'h20, 3);
        put(32'h20, enc_u(32'h10000, 7, 7'b0110111),      32'h24, 3);
        put(32'h24, enc_s(3, 1, 7, 0),                    32'h28, 4);
        exp_store(32'h1000_0003, 32'hA5A5_A5A5, 4'b1000);
        put(32'h28, enc_i(3, 0, 0, 6, 7'b0000011),        32'h2C, 5);
        put(32'h2C, enc_s(32'h108, 6, 0, 2),              32'h30, 4);
        exp_store(32'h108, 32'hFFFF_FF80, 4'b1111);
        put(32'h30, enc_i(3, 0, 4, 6, 7'b0000011),        32'h34, 5);
        put(32'h34, enc_s(32'h10C, 6, 0, 2),              32'h38, 4);
        exp_store(32'h10C, 32'h0000_0080, 4'b1111);
        put(32'h38, enc_i(2, 0, 1, 6, 7'b0000011),        32'h3C, 5);
        put(32'h3C, enc_s(32'h110, 6, 0, 2),              32'h40, 4);
        exp_store(32'h110, 32'hFFFF_80FF, 4'b1111);
        put(32'h40, enc_i(0, 0, 2, 6, 7'b0000011),        32'h44, 5);
        put(32'h44, enc_s(32'h114, 6, 0, 2),              32'h48, 4);
        exp_store(32'h114, 32'h80FF_7F01, 4'b1111);
        put(32'h48, enc_b(8, 0, 0, 1),                    32'h4C, 3);
        put(32'h4C, enc_i(-1, 0, 0, 8, 7'b0010011),       32'h50, 3);
        put(32'h50, enc_i(1, 0, 0, 9, 7'b0010011),        32'h54, 3);
        put(32'h54, enc_b(8, 9, 8, 4),                    32'h5C, 3);
        imem[22] = enc_s(32'h1F0, 0, 0, 2);
        put(32'h5C, enc_b(8, 9, 8, 6),                    32'h60, 3);
        put(32'h60, enc_i(32'h71, 0, 0, 10, 7'b0010011),  32'h64, 3);
        put(32'h64, enc_i(0, 10, 0, 10, 7'b1100111),      32'h70, 3);
        put(32'h70, enc_s(32'h118, 10, 0, 2),             32'h74, 4);
        exp_store(32'h118, 32'h68, 4'b1111);
        put(32'h74, enc_u(32'h80000, 11, 7'b0110111),     32'h78, 3);
        put(32'h78, enc_i(32'h404, 11, 5, 12, 7'b0010011), 32'h7C, 3);
        put(32'h7C, enc_s(32'h11C, 12, 0, 2),             32'h80, 4);
        exp_store(32'h11C, 32'hF800_0000, 4'b1111);
        put(32'h80, enc_i(7, 0, 0, 0, 7'b0010011),        32'h84, 3);
        put(32'h84, enc_s(32'h120, 0, 0, 2),              32'h88, 4);
        exp_store(32'h120, 32'h0, 4'b1111);
        put(32'h88, enc_u(32'h20000, 5, 7'b0110111),      32'h8C, 3);
        put(32'h8C, enc_s(0, 0, 5, 2),                    32'h90, 4);
        exp_store(32'h2000_0000, 32'h0, 4'b1111);
        put(32'h90, enc_s(2, 9, 7, 1),                    32'h94, 4);
        exp_store(32'h1000_0002, 32'h0001_0001, 4'b1100);
        put(32'h94, enc_r(0, 9, 8, 2, 13),                32'h98, 3);
        put(32'h98, enc_r(0, 9, 8, 3, 14),                32'h9C, 3);
        put(32'h9C, enc_r(32'h20, 13, 14, 0, 15),         32'hA0, 3);
        put(32'hA0, enc_s(32'h124, 15, 0, 2),             32'hA4, 4);
        exp_store(32'h124, 32'hFFFF_FFFF, 4'b1111);
        put(32'hA4, 32'h0000_0073,                        32'hA8, 3);
        imem[42] = enc_j(0, 0);

        // Reset held with no clock edge yet.
        #1;
        check("rst_araddr", bus.ibus_araddr_o, 32'h0);
        check("rst_wvalid", {31'b0, bus.dbus_wvalid_o}, 32'h0);
        check("rst_addr", bus.dbus_addr_o, 32'h0);
        check("rst_wdata", bus.dbus_wdata_o, 32'h0);
        check("rst_wstrb", {28'b0, bus.dbus_wstrb_o}, 32'h0);
        check("rst_state", {29'b0, bus.dbg_state}, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        tracking = 1'b1;

        for (int i = 0; i < 2000 && (trace_q.size() != 0 || exp_q.size() != 0); i++) @(negedge clk);
        repeat (12) @(negedge clk);
        check("fetch_trace_left", trace_q.size(), 0);
        check("stores_left", exp_q.size(), 0);
        check("loop_pc", bus.ibus_araddr_o, 32'hA8);

        // Asynchronous reset in the middle of an instruction.
        @(negedge clk);
        tracking = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_araddr", bus.ibus_araddr_o, 32'h0);
        check("midrst_wvalid", {31'b0, bus.dbus_wvalid_o}, 32'h0);
        check("midrst_state", {29'b0, bus.dbg_state}, 32'h0);
        check("midrst_wstrb", {28'b0, bus.dbus_wstrb_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
